// File: rtl/seven_seg_scan.sv
// Six-digit multiplexed 7-segment driver: dwell-based scan with an anti-ghost
// blank gap, hex decode, leading-zero blanking and a per-frame tick.
module seven_seg_scan #(
  parameter int unsigned DWELL = 131072,
  parameter int unsigned GAP   = 4,
  parameter int unsigned CNT_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] digits,
  input  logic [5:0]  dp_en,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [5:0]  sevenSegmentSel,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;
  logic             tick_q, tick_d;

  logic [5:0]       lz_blank;
  logic [3:0]       cur_digit;
  logic             cur_dp;
  logic             cur_blank;
  logic [5:0]       cur_sel;

  // Active-low a..g pattern, bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // A digit is a leading zero only if it and every digit to its left are 0.
  always_comb begin
    lz_blank    = '0;
    lz_blank[5] = blank_lz && (digits[23:20] == 4'h0);
    lz_blank[4] = lz_blank[5] && (digits[19:16] == 4'h0);
    lz_blank[3] = lz_blank[4] && (digits[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (digits[11:8]  == 4'h0);
    lz_blank[1] = lz_blank[2] && (digits[7:4]   == 4'h0);
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block can leave a latch behind.
  always_comb begin
    cur_digit = digits[3:0];
    cur_dp    = dp_en[0];
    cur_blank = 1'b0;
    cur_sel   = 6'b111110;
    case (idx_q)
      3'd1: begin
        cur_digit = digits[7:4];   cur_dp = dp_en[1];
        cur_blank = lz_blank[1];   cur_sel = 6'b111101;
      end
      3'd2: begin
        cur_digit = digits[11:8];  cur_dp = dp_en[2];
        cur_blank = lz_blank[2];   cur_sel = 6'b111011;
      end
      3'd3: begin
        cur_digit = digits[15:12]; cur_dp = dp_en[3];
        cur_blank = lz_blank[3];   cur_sel = 6'b110111;
      end
      3'd4: begin
        cur_digit = digits[19:16]; cur_dp = dp_en[4];
        cur_blank = lz_blank[4];   cur_sel = 6'b101111;
      end
      3'd5: begin
        cur_digit = digits[23:20]; cur_dp = dp_en[5];
        cur_blank = lz_blank[5];   cur_sel = 6'b011111;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        tick_d = (idx_q == 3'd5);
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // seg tracks idx even during the gap so seg and select never disagree.
    sel_d = (!en || (cnt_q < CNT_GAP)) ? 6'b111111 : cur_sel;
    seg_d = {~cur_dp, cur_blank ? 7'h7F : hex_to_seg(cur_digit)};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 8'hFF;
      sel_q  <= 6'b111111;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign seg             = seg_q;
  assign sevenSegmentSel = sel_q;
  assign frame_tick      = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (DWELL=8, GAP=2): a cycle scoreboard plus
// directed checks for start-up, decode, scan order, blanking, freeze and reset.
module tb_seven_seg_scan;

  localparam int DWELL = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] digits;
  logic [5:0]  dp_en;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_tick;

  seven_seg_scan #(.DWELL(DWELL), .GAP(GAP), .CNT_W(25)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .digits          (digits),
    .dp_en           (dp_en),
    .blank_lz        (blank_lz),
    .seg             (seg),
    .sevenSegmentSel (sel),
    .frame_tick      (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] sel;
    logic       tick;
  } out_t;

  out_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt = 0;
  int   m_idx = 0;

  logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [5:0] sel_tab [6]  = '{6'b111110, 6'b111101, 6'b111011,
                               6'b110111, 6'b101111, 6'b011111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge, from the model's pre-edge state.
  function automatic out_t model_out();
    out_t       o;
    logic [3:0] d;
    logic       blank;
    if (!rst) begin
      o.seg  = 8'hFF;
      o.sel  = 6'b111111;
      o.tick = 1'b0;
      return o;
    end
    d     = digits[4*m_idx +: 4];
    blank = blank_lz && (m_idx != 0);
    for (int j = m_idx; j < 6; j++)
      if (digits[4*j +: 4] != 4'h0) blank = 1'b0;
    o.seg  = {~dp_en[m_idx], blank ? 7'h7F : dec_tab[d][6:0]};
    o.sel  = (!en || m_cnt < GAP) ? 6'b111111 : sel_tab[m_idx];
    o.tick = en && (m_cnt == DWELL - 1) && (m_idx == 5);
    return o;
  endfunction

  // One clock: push expectation, advance model, sample at negedge, compare.
  task automatic cycle();
    out_t e;
    sb_q.push_back(model_out());
    if (!rst) begin
      m_cnt = 0;
      m_idx = 0;
    end else if (en) begin
      if (m_cnt == DWELL - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == 5) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("sb_seg", seg, e.seg);
    check("sb_sel", sel, e.sel);
    check("sb_tick", frame_tick, e.tick);
  endtask

  initial begin
    int         hits;
    int         ticks;
    int         last_tick;
    int         pos;
    int         found;
    logic [5:0] prev_sel;
    logic [7:0] lz_exp [6];

    rst      = 1'b0;
    en       = 1'b1;
    digits   = 24'h012345;
    dp_en    = 6'b000000;
    blank_lz = 1'b0;

    // Reset and start-up sequence.
    repeat (3) cycle();
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", sel, 6'b111111);
    check("rst_tick", frame_tick, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("start_sel", sel, (i < 2) ? 6'b111111 : (i < 8) ? 6'b111110 :
                              (i < 10) ? 6'b111111 : 6'b111101);
      check("start_seg", seg, (i < 8) ? 8'h92 : 8'h99);
    end

    // Full hex decode on digit 0.
    for (int v = 0; v < 16; v++) begin
      digits[3:0] = 4'(v);
      hits = 0;
      repeat (48) begin
        cycle();
        if (sel == 6'b111110) begin
          check($sformatf("hex_%0h", v), seg, dec_tab[v]);
          hits++;
        end
      end
      check("hex_hits", hits, 6);
    end
    digits = 24'h012345;

    // Scan order and frame tick over two frames.
    ticks     = 0;
    last_tick = -1;
    pos       = -1;
    prev_sel  = 6'b111111;
    for (int c = 0; c < 96; c++) begin
      cycle();
      if (frame_tick) begin
        ticks++;
        check("tick_on_wrap", sel, 6'b011111);
        if (last_tick >= 0) check("tick_period", c - last_tick, 48);
        last_tick = c;
      end
      if (sel != 6'b111111 && sel != prev_sel) begin
        if (pos >= 0) check("scan_order", sel, sel_tab[(pos + 1) % 6]);
        for (int k = 0; k < 6; k++)
          if (sel_tab[k] == sel) pos = k;
      end
      prev_sel = sel;
    end
    check("tick_count", ticks, 2);

    // Leading-zero blanking with a dp on a blanked digit.
    digits   = 24'h000070;
    blank_lz = 1'b1;
    dp_en    = 6'b000100;
    lz_exp   = '{8'hC0, 8'hF8, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    hits = 0;
    repeat (48) begin
      cycle();
      for (int k = 0; k < 6; k++)
        if (sel == sel_tab[k]) begin
          check($sformatf("lz_d%0d", k), seg, lz_exp[k]);
          hits++;
        end
    end
    check("lz_hits", hits, 36);

    digits = 24'h000000;
    dp_en  = 6'b000000;
    lz_exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    hits = 0;
    repeat (48) begin
      cycle();
      for (int k = 0; k < 6; k++)
        if (sel == sel_tab[k]) begin
          check($sformatf("zero_d%0d", k), seg, lz_exp[k]);
          hits++;
        end
    end
    check("zero_hits", hits, 36);

    // Enable freeze in the middle of digit 3's dwell.
    digits   = 24'h012345;
    blank_lz = 1'b0;
    found    = 0;
    for (int c = 0; c < 60; c++) begin
      if (m_idx == 3 && m_cnt == 4) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("freeze_reach", found, 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("freeze_sel", sel, 6'b111111);
      check("freeze_tick", frame_tick, 1'b0);
    end
    en   = 1'b1;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (c == 0) check("resume_first", sel, 6'b110111);
      if (sel == 6'b110111) hits++;
    end
    check("resume_dwell", hits, 4);

    // Reset while digit 4 is lit.
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (m_idx == 4 && m_cnt == 5) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("midrst_reach", found, 1);
    check("midrst_lit", sel, 6'b101111);
    rst = 1'b0;
    cycle();
    check("midrst_seg", seg, 8'hFF);
    check("midrst_sel", sel, 6'b111111);
    check("midrst_tick", frame_tick, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("restart_sel", sel, (i < 2) ? 6'b111111 : 6'b111110);
      check("restart_seg", seg, 8'h92);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Six-digit multiplexed 7-segment display driver.
- Sits downstream of the team's counter/timer stages. It consumes six packed hex digits plus decimal-point enables and drives the board's shared active-low segment bus and active-low digit selects.
- Owns scan timing, hex-to-segment decode, leading-zero blanking and an anti-ghosting blank gap, so counting blocks no longer embed display logic.

Parameters:
- DWELL, 131072: clock cycles each digit is selected; legal range 2..2^25-1.
- GAP, 4: cycles at the start of each dwell with all selects off (anti-ghost); legal 0..DWELL-1.
- CNT_W, 25: width of the dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- en  input  1  1 = scanning; 0 = display dark and scan frozen.
- digits  input  24  digit k = digits[4k+3:4k]; k=0 is rightmost; hex 0-F.
- dp_en  input  6  bit k = 1 lights the decimal point of digit k.
- blank_lz  input  1  1 = blank leading zeros.
- seg  output  8  active-low; bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
- sevenSegmentSel  output  6  active-low one-hot digit select; bit k = digit k.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 5 to digit 0.

Behaviour:
- Reset (rst=0 at posedge):
  - internal: idx=0, cnt=0.
  - outputs: seg=8'hFF, sevenSegmentSel=6'b111111, frame_tick=0.
  - Reset mid-scan aborts immediately, with no partial dwell carried over.
- Dwell counter (en=1):
  - cnt increments each cycle.
  - At cnt==DWELL-1: cnt<=0 and idx<=idx+1; idx 5 wraps to 0.
  - On the 5->0 wrap edge, frame_tick<=1; otherwise frame_tick=0.
- en=0: cnt and idx hold; frame_tick=0.
- Output registers, 1-cycle latency. Outputs after edge t+1 are computed from cnt, idx and inputs sampled at edge t:
  - sevenSegmentSel = 6'b111111 if en=0 or cnt<GAP; else ~(6'b1<<idx).
  - seg = {~dp, ~pattern} for digit idx.
  - seg is updated every cycle, even while selects are off, so seg and select always correspond to the same idx.
  - Live input changes appear on the next edge; there is no per-dwell snapshot.
- Decode, active-low seg[7:0] with dp off, hex 0-F:
  - 0-7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8-F: 80, 90, 88, 83, C6, A1, 86, 8E.
- Leading-zero blanking:
  - Digit k (k=1..5) is blank when blank_lz=1 and digits 5 down to k are all 0.
  - Digit 0 is never blanked.
  - A blank digit has seg[6:0]=7'h7F; its dp still follows dp_en[k].
- dp: seg[7] = ~dp_en[idx], independent of blanking.
- Frame timing: one full frame = 6*DWELL cycles while en=1.
- No combinational path from inputs to outputs.

Test Plan (bench parameters DWELL=8, GAP=2):
- Reset/start:
  - Stimulus: hold rst=0 for 3 cycles, release with en=1, digits=24'h012345, blank_lz=0.
  - Required: during reset, seg=FF and sel=111111. Sel stays 111111 for 2 cycles after the first post-reset edge, then 111110 with seg=92 ("5") for 6 cycles. Sel then goes 111111 for 2 cycles, then 111101 with seg=99.
- Full hex decode:
  - Stimulus: step digit 0 through 0-F with en=1.
  - Required: seg matches the decode table exactly while sel=111110.
- Scan order and frame_tick:
  - Stimulus: free-run 2 frames.
  - Required: select sequence 111110, 111101, 111011, 110111, 101111, 011111, repeating with GAP-off periods between digits. frame_tick pulses exactly once per 48 cycles, on the 5->0 wrap.
- Leading-zero blanking:
  - Stimulus: digits=24'h000070, blank_lz=1, dp_en=6'b000100.
  - Required:
    - digits 5,4,3: seg=FF.
    - digit 2: seg=7F (blank with dp).
    - digit 1: seg=F8.
    - digit 0: seg=C0.
    - With digits=24'h000000, digit 0 shows C0 and all others FF.
- Enable freeze:
  - Stimulus: drop en mid-dwell of digit 3 for 10 cycles, then restore.
  - Required: sel=111111 one edge after en falls. On restore, digit 3 resumes with the remaining dwell count. frame_tick stays 0 while en=0.
- Reset mid-operation:
  - Stimulus: assert rst=0 for one cycle while digit 4 is lit.
  - Required: next edge gives seg=FF, sel=111111; the scan restarts at digit 0 with a full GAP+dwell.
